// File: rtl/ecdsa_csr_pkg.sv
// Shared constants for the ECDSA control/status register block.
package ecdsa_csr_pkg;

    localparam int unsigned DATA_W      = 32;
    localparam int unsigned STRB_W      = DATA_W / 8;

    localparam int unsigned CSR_COMMAND = 0;
    localparam int unsigned CSR_RXADDR  = 1;
    localparam int unsigned CSR_TXADDR  = 2;
    localparam int unsigned CSR_STATUS  = 0;

    localparam logic [1:0]  RESP_OKAY   = 2'b00;
    localparam logic [1:0]  RESP_SLVERR = 2'b10;

endpackage

// File: rtl/ecdsa_csr_axil_slave.sv
// AXI4-Lite responder exposing the ECDSA CSR bank; word 0 is write-COMMAND / read-STATUS.
module ecdsa_csr_axil_slave
    import ecdsa_csr_pkg::*;
#(
    parameter int unsigned NREGS  = 8,
    parameter int unsigned ADDR_W = 12
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [ADDR_W-1:0]       s_axi_csrs_awaddr,
    input  logic                    s_axi_csrs_awvalid,
    output logic                    s_axi_csrs_awready,
    input  logic [DATA_W-1:0]       s_axi_csrs_wdata,
    input  logic [STRB_W-1:0]       s_axi_csrs_wstrb,
    input  logic                    s_axi_csrs_wvalid,
    output logic                    s_axi_csrs_wready,
    output logic [1:0]              s_axi_csrs_bresp,
    output logic                    s_axi_csrs_bvalid,
    input  logic                    s_axi_csrs_bready,
    input  logic [ADDR_W-1:0]       s_axi_csrs_araddr,
    input  logic                    s_axi_csrs_arvalid,
    output logic                    s_axi_csrs_arready,
    output logic [DATA_W-1:0]       s_axi_csrs_rdata,
    output logic [1:0]              s_axi_csrs_rresp,
    output logic                    s_axi_csrs_rvalid,
    input  logic                    s_axi_csrs_rready,
    output logic [NREGS*DATA_W-1:0] regs_o,
    output logic                    cmd_wr_o,
    input  logic [DATA_W-1:0]       status_i
);

    localparam int unsigned IDX_W = ADDR_W - 2;
    localparam int unsigned SEL_W = (NREGS > 1) ? $clog2(NREGS) : 1;

    logic [NREGS-1:0][DATA_W-1:0] regs_q;

    logic                 aw_full;
    logic [IDX_W-1:0]     aw_idx;
    logic                 w_full;
    logic [DATA_W-1:0]    w_data;
    logic [STRB_W-1:0]    w_strb;

    logic                 aw_hs, w_hs, ar_hs, b_hs;
    logic                 have_aw, have_w, commit;
    logic                 aw_full_next, w_full_next, bvalid_next, rvalid_next;
    logic [IDX_W-1:0]     wr_idx, rd_idx;
    logic [SEL_W-1:0]     wr_sel, rd_sel;
    logic [DATA_W-1:0]    wr_data, rd_data;
    logic [STRB_W-1:0]    wr_strb;
    logic                 wr_in_range, rd_in_range;
    logic                 unused_addr_lsbs;

    assign unused_addr_lsbs = ^{s_axi_csrs_awaddr[1:0], s_axi_csrs_araddr[1:0]};

    // Commit happens on the first edge where address and data are both available.
    always_comb begin
        aw_hs        = s_axi_csrs_awvalid & s_axi_csrs_awready;
        w_hs         = s_axi_csrs_wvalid  & s_axi_csrs_wready;
        ar_hs        = s_axi_csrs_arvalid & s_axi_csrs_arready;
        b_hs         = s_axi_csrs_bvalid  & s_axi_csrs_bready;
        have_aw      = aw_full | aw_hs;
        have_w       = w_full  | w_hs;
        commit       = have_aw & have_w;
        aw_full_next = have_aw & ~commit;
        w_full_next  = have_w  & ~commit;
        bvalid_next  = commit | (s_axi_csrs_bvalid & ~b_hs);
        rvalid_next  = ar_hs  | (s_axi_csrs_rvalid & ~s_axi_csrs_rready);

        wr_idx       = aw_full ? aw_idx : s_axi_csrs_awaddr[ADDR_W-1:2];
        wr_data      = w_full  ? w_data : s_axi_csrs_wdata;
        wr_strb      = w_full  ? w_strb : s_axi_csrs_wstrb;
        wr_sel       = SEL_W'(wr_idx);
        wr_in_range  = 32'(wr_idx) < NREGS;

        rd_idx       = s_axi_csrs_araddr[ADDR_W-1:2];
        rd_sel       = SEL_W'(rd_idx);
        rd_in_range  = 32'(rd_idx) < NREGS;
        rd_data      = '0;
        if (rd_in_range) begin
            rd_data = (rd_idx == IDX_W'(CSR_STATUS)) ? status_i : regs_q[rd_sel];
        end
    end

    // Write buffers, B channel and write-side readies.
    always_ff @(posedge clk) begin
        if (rst) begin
            aw_full            <= 1'b0;
            aw_idx             <= '0;
            w_full             <= 1'b0;
            w_data             <= '0;
            w_strb             <= '0;
            s_axi_csrs_awready <= 1'b0;
            s_axi_csrs_wready  <= 1'b0;
            s_axi_csrs_bvalid  <= 1'b0;
            s_axi_csrs_bresp   <= 2'b00;
            cmd_wr_o           <= 1'b0;
        end else begin
            aw_full <= aw_full_next;
            w_full  <= w_full_next;
            if (aw_hs && !commit) aw_idx <= s_axi_csrs_awaddr[ADDR_W-1:2];
            if (w_hs && !commit) begin
                w_data <= s_axi_csrs_wdata;
                w_strb <= s_axi_csrs_wstrb;
            end
            s_axi_csrs_bvalid <= bvalid_next;
            if (commit) s_axi_csrs_bresp <= wr_in_range ? RESP_OKAY : RESP_SLVERR;
            // Readies stay low for one extra cycle after the B handshake.
            s_axi_csrs_awready <= ~aw_full_next & ~bvalid_next & ~s_axi_csrs_bvalid;
            s_axi_csrs_wready  <= ~w_full_next  & ~bvalid_next & ~s_axi_csrs_bvalid;
            cmd_wr_o <= commit & wr_in_range & (wr_idx == IDX_W'(CSR_COMMAND));
        end
    end

    // Read response: data and status are captured at the AR handshake.
    always_ff @(posedge clk) begin
        if (rst) begin
            s_axi_csrs_arready <= 1'b0;
            s_axi_csrs_rvalid  <= 1'b0;
            s_axi_csrs_rdata   <= '0;
            s_axi_csrs_rresp   <= 2'b00;
        end else begin
            s_axi_csrs_rvalid  <= rvalid_next;
            s_axi_csrs_arready <= ~rvalid_next & ~s_axi_csrs_rvalid;
            if (ar_hs) begin
                s_axi_csrs_rdata <= rd_data;
                s_axi_csrs_rresp <= rd_in_range ? RESP_OKAY : RESP_SLVERR;
            end
        end
    end

    // Register file with per-byte write enables.
    always_ff @(posedge clk) begin
        if (rst) begin
            regs_q <= '0;
        end else if (commit && wr_in_range) begin
            for (int b = 0; b < int'(STRB_W); b++) begin
                if (wr_strb[b]) regs_q[wr_sel][b*8 +: 8] <= wr_data[b*8 +: 8];
            end
        end
    end

    assign regs_o = regs_q;

endmodule

// File: tb/tb_ecdsa_csr_axil_slave.sv
// Randomized AXI-Lite bench for ecdsa_csr_axil_slave against a word-array reference model.
module tb_ecdsa_csr_axil_slave;

    localparam int NREGS  = 8;
    localparam int ADDR_W = 12;
    localparam int BOUND  = 50;

    logic                   clk = 1'b0;
    logic                   rst;
    logic [ADDR_W-1:0]      awaddr, araddr;
    logic                   awvalid, awready, wvalid, wready;
    logic [31:0]            wdata;
    logic [3:0]             wstrb;
    logic [1:0]             bresp, rresp;
    logic                   bvalid, bready, arvalid, arready, rvalid, rready;
    logic [31:0]            rdata;
    logic [NREGS*32-1:0]    regs_o;
    logic                   cmd_wr;
    logic [31:0]            status;

    logic [31:0]            mregs [NREGS];
    int                     n_checks = 0;
    int                     n_fail   = 0;

    ecdsa_csr_axil_slave #(.NREGS(NREGS), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .rst(rst),
        .s_axi_csrs_awaddr(awaddr), .s_axi_csrs_awvalid(awvalid), .s_axi_csrs_awready(awready),
        .s_axi_csrs_wdata(wdata), .s_axi_csrs_wstrb(wstrb),
        .s_axi_csrs_wvalid(wvalid), .s_axi_csrs_wready(wready),
        .s_axi_csrs_bresp(bresp), .s_axi_csrs_bvalid(bvalid), .s_axi_csrs_bready(bready),
        .s_axi_csrs_araddr(araddr), .s_axi_csrs_arvalid(arvalid), .s_axi_csrs_arready(arready),
        .s_axi_csrs_rdata(rdata), .s_axi_csrs_rresp(rresp),
        .s_axi_csrs_rvalid(rvalid), .s_axi_csrs_rready(rready),
        .regs_o(regs_o), .cmd_wr_o(cmd_wr), .status_i(status)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout required completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h required %0h", tag, got, exp);
        end
    endtask

    task automatic check_regs(input string tag);
        for (int i = 0; i < NREGS; i++)
            check($sformatf("%s_w%0d", tag, i), regs_o[i*32 +: 32], mregs[i]);
    endtask

    // Full write transaction with independent AW/W start delays.
    task automatic write_txn(input logic [ADDR_W-1:0] addr, input logic [31:0] data,
                             input logic [3:0] strb, input int aw_dly, input int w_dly,
                             input bit finish_b);
        int  idx;
        bit  in_rng;
        idx    = int'(addr[ADDR_W-1:2]);
        in_rng = idx < NREGS;
        fork
            begin
                int n = 0;
                repeat (aw_dly) @(negedge clk);
                awaddr = addr; awvalid = 1'b1;
                while (!awready && n < BOUND) begin @(negedge clk); n++; end
                check("aw_timeout", 64'(n >= BOUND), 0);
                @(negedge clk);
                awvalid = 1'b0; awaddr = ADDR_W'($urandom);
            end
            begin
                int n = 0;
                repeat (w_dly) @(negedge clk);
                wdata = data; wstrb = strb; wvalid = 1'b1;
                while (!wready && n < BOUND) begin @(negedge clk); n++; end
                check("w_timeout", 64'(n >= BOUND), 0);
                @(negedge clk);
                wvalid = 1'b0; wdata = $urandom;
            end
        join
        if (in_rng)
            for (int b = 0; b < 4; b++)
                if (strb[b]) mregs[idx][8*b +: 8] = data[8*b +: 8];
        check("bvalid_lat", bvalid, 1);
        check("bresp", bresp, in_rng ? 2'b00 : 2'b10);
        check("cmd_wr", cmd_wr, 64'(in_rng && idx == 0));
        check_regs("wr");
        if (finish_b) begin
            @(negedge clk);
            check("bvalid_clr", bvalid, 0);
            check("cmd_wr_once", cmd_wr, 0);
            check("aw_gap", awready, 0);
            @(negedge clk);
            check("aw_back", awready, 1);
            check("w_back", wready, 1);
        end
    endtask

    task automatic read_txn(input logic [ADDR_W-1:0] addr, input logic [31:0] stat);
        int          idx, n;
        logic [31:0] exp_data;
        logic [1:0]  exp_resp;
        idx = int'(addr[ADDR_W-1:2]);
        if (idx >= NREGS) begin exp_data = 0; exp_resp = 2'b10; end
        else begin exp_data = (idx == 0) ? stat : mregs[idx]; exp_resp = 2'b00; end
        status = stat; araddr = addr; arvalid = 1'b1;
        n = 0;
        while (!arready && n < BOUND) begin @(negedge clk); n++; end
        check("ar_timeout", 64'(n >= BOUND), 0);
        @(negedge clk);
        arvalid = 1'b0; status = $urandom;
        check("rvalid_lat", rvalid, 1);
        check("rdata", rdata, exp_data);
        check("rresp", rresp, exp_resp);
        @(negedge clk);
        check("rvalid_clr", rvalid, 0);
    endtask

    initial begin
        rst = 1'b1; awaddr = '0; awvalid = 0; wdata = '0; wstrb = '0; wvalid = 0;
        bready = 1'b1; araddr = '0; arvalid = 0; rready = 1'b1; status = '0;
        foreach (mregs[i]) mregs[i] = '0;
        repeat (3) @(negedge clk);
        check("rst_awready", awready, 0);
        check("rst_arready", arready, 0);
        check("rst_regs", 64'(|regs_o), 0);
        rst = 1'b0;
        @(negedge clk);
        check("init_awready", awready, 1);
        check("init_wready", wready, 1);
        check("init_arready", arready, 1);

        // Basic writes and readback
        write_txn(12'h004, 32'h0000_0000, 4'hF, 0, 0, 1);
        write_txn(12'h008, 32'h0000_0080, 4'hF, 0, 0, 1);
        read_txn(12'h008, 32'h0);

        // W three cycles ahead of AW, COMMAND write
        write_txn(12'h000, 32'h0000_0001, 4'hF, 3, 0, 1);
        check("cmd_word0", regs_o[31:0], 32'h1);

        // STATUS polling leaves COMMAND intact
        read_txn(12'h000, 32'h0);
        read_txn(12'h000, 32'h1);
        check("word0_kept", regs_o[31:0], 32'h1);

        // Byte-lane merge
        write_txn(12'h00C, 32'h1122_3344, 4'hF, 0, 1, 1);
        write_txn(12'h00C, 32'hAABB_CCDD, 4'b0010, 1, 0, 1);
        check("strb_merge", regs_o[3*32 +: 32], 32'h1122_CC44);

        // Out-of-range access
        write_txn(12'h100, 32'hDEAD_BEEF, 4'hF, 0, 0, 1);
        read_txn(12'h100, 32'h5);

        // Simultaneous write and read of the same word returns old value
        begin
            int n = 0;
            logic [31:0] old;
            while (!(awready && wready && arready) && n < BOUND) begin @(negedge clk); n++; end
            check("same_timeout", 64'(n >= BOUND), 0);
            old = mregs[4];
            awaddr = 12'h010; wdata = 32'h0BAD_F00D; wstrb = 4'hF; araddr = 12'h010;
            awvalid = 1'b1; wvalid = 1'b1; arvalid = 1'b1;
            @(negedge clk);
            awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
            mregs[4] = 32'h0BAD_F00D;
            check("same_rdata", rdata, old);
            check("same_bvalid", bvalid, 1);
            check("same_word4", regs_o[4*32 +: 32], mregs[4]);
            repeat (2) @(negedge clk);
        end

        // Randomized traffic
        for (int it = 0; it < 60; it++) begin
            logic [ADDR_W-1:0] a;
            if ($urandom_range(0, 7) == 0) a = ADDR_W'($urandom_range(NREGS, 1023) << 2);
            else a = ADDR_W'(($urandom_range(0, NREGS-1) << 2) | $urandom_range(0, 3));
            if ($urandom_range(0, 1) == 1)
                write_txn(a, $urandom, 4'($urandom), $urandom_range(0, 3), $urandom_range(0, 3), 1);
            else
                read_txn(a, $urandom);
        end

        // B backpressure, then reset while the response is pending
        bready = 1'b0;
        write_txn(12'h014, 32'h1234_5678, 4'hF, 0, 0, 0);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("bp_bvalid", bvalid, 1);
            check("bp_awready", awready, 0);
            check("bp_wready", wready, 0);
        end
        rst = 1'b1;
        @(negedge clk);
        foreach (mregs[i]) mregs[i] = '0;
        check("mid_rst_ready", 64'({awready, wready, arready}), 0);
        check("mid_rst_resp", 64'({bvalid, rvalid, bresp, rresp, cmd_wr}), 0);
        check("mid_rst_rdata", rdata, 0);
        check("mid_rst_regs", 64'(|regs_o), 0);
        bready = 1'b1;
        rst = 1'b0;
        @(negedge clk);
        check("rel_ready", 64'({awready, wready, arready}), 64'b111);
        check("rel_bvalid", bvalid, 0);
        read_txn(12'h014, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ecdsa_csr_axil_slave.md
# ecdsa_csr_axil_slave

AXI4-Lite responder that terminates the `s_axi_csrs` control channel of the ECDSA project and exposes a small bank of 32-bit CSRs to the accelerator core. Host software, or a bench acting as AXI-Lite initiator, uses it to write COMMAND, RXADDR and TXADDR, and to poll STATUS. The block sits between the AXI-Lite interconnect and the ECDSA core. Read and write channels are independent.

## Interface
- `NREGS`, default 8: number of 32-bit CSR words; legal word index range is 0..NREGS-1.
- `ADDR_W`, default 12: AXI-Lite byte address width.

- `clk` in 1: single clock for all logic.
- `rst` in 1: synchronous, active-high reset.
- `s_axi_csrs_awaddr` in ADDR_W: write address.
- `s_axi_csrs_awvalid` in 1 / `s_axi_csrs_awready` out 1: AW handshake.
- `s_axi_csrs_wdata` in 32 / `s_axi_csrs_wstrb` in 4: write data and byte enables.
- `s_axi_csrs_wvalid` in 1 / `s_axi_csrs_wready` out 1: W handshake.
- `s_axi_csrs_bresp` out 2 / `s_axi_csrs_bvalid` out 1 / `s_axi_csrs_bready` in 1: B channel.
- `s_axi_csrs_araddr` in ADDR_W / `s_axi_csrs_arvalid` in 1 / `s_axi_csrs_arready` out 1: AR channel.
- `s_axi_csrs_rdata` out 32 / `s_axi_csrs_rresp` out 2 / `s_axi_csrs_rvalid` out 1 / `s_axi_csrs_rready` in 1: R channel.
- `regs_o` out NREGS*32: current CSR contents. Word i occupies bits [32i+31:32i]. Word 0 is COMMAND, word 1 is RXADDR, word 2 is TXADDR.
- `cmd_wr_o` out 1: one-cycle pulse when word 0 is written.
- `status_i` in 32: core status. Bit 0 is done.

## Operation
- Decode: word index = `addr[ADDR_W-1:2]`. Bits [1:0] are ignored. An index ≥ NREGS is out of range.
- Write channel:
  - AW and W are captured independently into one-entry buffers, in either order or in the same cycle.
  - A channel's ready is high only while its buffer is empty and no B response is pending.
  - The commit edge is the first edge at which both address and data are available, whether buffered or handshaking on that edge. At that edge:
    - each byte lane with `wstrb[b]=1` updates the addressed word;
    - both buffers clear;
    - `bvalid` rises.
  - `bresp` is 2'b00 (OKAY) for an in-range address. It is 2'b10 (SLVERR) for an out-of-range address, and in that case no register changes.
  - `cmd_wr_o` pulses in the cycle after committing an in-range write to word 0, even when `wstrb` is 0.
- Read channel:
  - `arready` is high when no R response is pending.
  - On the AR handshake edge, the block latches `rdata` and `rresp` and raises `rvalid`.
  - Word 0 reads return `status_i`; word 0 is write-COMMAND / read-STATUS. Other in-range words return the register value.
  - An out-of-range read returns `rdata=0` and `rresp=2'b10`.
- Read and write of the same word on the same edge: the read returns the pre-write value.

## Timing
- While `rst=1`, every output is 0: all readies, `bvalid`, `rvalid`, `bresp`, `rresp`, `rdata`, `regs_o` and `cmd_wr_o`.
- `awready`, `wready` and `arready` rise on the first edge after `rst` falls.
- Write path:
  - AW+W presented together with readies high: commit and `bvalid=1` one cycle after the handshake.
  - Each ready drops the cycle after its own handshake, so a valid held one extra cycle is not re-accepted.
  - `bvalid` holds until `bvalid&bready`. The readies re-assert on the edge after the B handshake.
  - Back-to-back throughput is one write per 3 cycles minimum, with `bready` already high.
- Read path:
  - `rvalid` rises one cycle after the AR handshake. `rdata` and `rresp` are stable while `rvalid=1`.
  - `arready` re-asserts on the edge after `rvalid&rready`.
- `status_i` is sampled only at the AR handshake edge.
- Reset mid-transaction: all pending handshakes and buffered AW/W are discarded, and registers clear. No B or R response is produced for a lost transaction.

## Structure
- Package `ecdsa_csr_pkg`:
  - word-index constants `CSR_COMMAND=0`, `CSR_RXADDR=1`, `CSR_TXADDR=2`, `CSR_STATUS=0`;
  - response constants `RESP_OKAY=2'b00`, `RESP_SLVERR=2'b10`.
- Single module, no sub-modules. Write-buffer, read-response and register-file logic live in separate always blocks.

## Test plan
- Reset, then write addr 0x004 data 0x00000000, then addr 0x008 data 0x00000080 -> `bresp=0`; `regs_o` word1=0x00000000 and word2=0x00000080; readback of 0x008 returns 0x00000080.
- W presented 3 cycles before AW (addr 0x000, data 0x1) -> no commit until AW handshake; commit one cycle later; `cmd_wr_o` pulses once; word0=0x00000001.
- Poll 0x000 with `status_i=0` then `status_i=1` -> `rdata` 0x0 then 0x1, `rresp=0`; word0 unaffected.
- `wstrb=4'b0010`, data 0xAABBCCDD to 0x00C when the word is 0x11223344 -> result 0x1122CC44.
- Write and read addr 0x100 (index 64 ≥ 8) -> `bresp=2'b10`, no register change; `rresp=2'b10`, `rdata=0`.
- Hold `bready=0` for 10 cycles after a write -> `bvalid` stays 1 and `awready`/`wready` stay 0; assert `rst` mid-wait -> all outputs 0 next edge; readies return one edge after release.
